// File: rtl/blinker_multi.sv
// rtl/blinker_multi.sv - multi-channel OFF/ON/BLINK/BURST indicator driver on one shared divider
// Optional burst_done output enabled by defining BLINKER_BURST_DONE_EN.
module blinker_multi #(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100000000,
    parameter int BLINK_FREQUENCY_IN_HZ       = 2,
    parameter int CHANNELS                    = 4,
    parameter int BURST_COUNT                 = 3,
    parameter int GAP_HALF_PERIODS            = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2*CHANNELS-1:0] mode,
    output logic                  tick,
`ifdef BLINKER_BURST_DONE_EN
    output logic [CHANNELS-1:0]   blink,
    output logic [CHANNELS-1:0]   burst_done
`else
    output logic [CHANNELS-1:0]   blink
`endif
);

    localparam int HALF = BOARD_CLOCK_FREQUENCY_IN_HZ / (2 * BLINK_FREQUENCY_IN_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PW   = $clog2(BURST_COUNT + 1);
    localparam int GW   = $clog2(GAP_HALF_PERIODS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(HALF - 1);
    localparam logic [PW-1:0] PULSE_MAX = PW'(BURST_COUNT);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALF_PERIODS - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    if (HALF < 1) begin : g_half_check
        $error("blinker_multi: HALF must be at least 1");
    end

    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         phase_q, phase_d;
    logic [CHANNELS-1:0][1:0]     state_q, state_d;
    logic [CHANNELS-1:0][PW-1:0]  pulse_q, pulse_d;
    logic [CHANNELS-1:0][GW-1:0]  gap_q, gap_d;
    logic [CHANNELS-1:0]          blink_q, blink_d;
`ifdef BLINKER_BURST_DONE_EN
    logic [CHANNELS-1:0]          done_q, done_d;
`endif

    // tick is the enabled wrap cycle of the shared divider; reset gating keeps it low for HALF==1
    always_comb begin
        tick    = rst & enable & (cnt_q == CNT_LAST);
        cnt_d   = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
        phase_d = phase_q ^ tick;
    end

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        gap_d   = gap_q;
        blink_d = '0;
`ifdef BLINKER_BURST_DONE_EN
        done_d  = '0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode[2*i +: 2] != MODE_BURST) begin
                state_d[i] = S_IDLE;
                pulse_d[i] = '0;
                gap_d[i]   = '0;
            end else if (tick) begin
                case (state_q[i])
                    S_IDLE: begin
                        state_d[i] = S_ON;
                        pulse_d[i] = PW'(1);
                    end
                    S_ON: begin
                        if (pulse_q[i] == PULSE_MAX) begin
                            state_d[i] = S_GAP;
                            gap_d[i]   = '0;
`ifdef BLINKER_BURST_DONE_EN
                            done_d[i]  = 1'b1;
`endif
                        end else begin
                            state_d[i] = S_OFF;
                        end
                    end
                    S_OFF: begin
                        state_d[i] = S_ON;
                        pulse_d[i] = pulse_q[i] + PW'(1);
                    end
                    default: begin
                        if (gap_q[i] == GAP_LAST) begin
                            state_d[i] = S_ON;
                            pulse_d[i] = PW'(1);
                        end else begin
                            gap_d[i] = gap_q[i] + GW'(1);
                        end
                    end
                endcase
            end

            // outputs follow next-state values so every mode change lands on the very next edge
            case (mode[2*i +: 2])
                MODE_OFF:   blink_d[i] = 1'b0;
                MODE_ON:    blink_d[i] = 1'b1;
                MODE_BLINK: blink_d[i] = phase_d;
                default:    blink_d[i] = (state_d[i] == S_ON);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            state_q <= '0;
            pulse_q <= '0;
            gap_q   <= '0;
            blink_q <= '0;
`ifdef BLINKER_BURST_DONE_EN
            done_q  <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
            gap_q   <= gap_d;
            blink_q <= blink_d;
`ifdef BLINKER_BURST_DONE_EN
            done_q  <= done_d;
`endif
        end
    end

    assign blink = blink_q;
`ifdef BLINKER_BURST_DONE_EN
    assign burst_done = done_q;
`endif

endmodule

// File: tb/tb_blinker_multi.sv
// tb/tb_blinker_multi.sv - scoreboard bench for blinker_multi (HALF=10, 2 channels, 2-pulse bursts, 3-half-period gap)
module tb_blinker_multi;

    localparam int CH    = 2;
    localparam int BC    = 2;
    localparam int GHP   = 3;
    localparam int HALFP = 10;
    localparam int PER   = 2 * BC - 1 + GHP;

    localparam int K_TICK  = 0;
    localparam int K_BLINK = 1;
    localparam int K_DONE  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [2*CH-1:0] mode;
    logic          tick;
    logic [CH-1:0] blink;
`ifdef BLINKER_BURST_DONE_EN
    logic [CH-1:0] burst_done;
`endif

    always #5 clk = ~clk;

    blinker_multi #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(20),
        .BLINK_FREQUENCY_IN_HZ      (1),
        .CHANNELS                   (CH),
        .BURST_COUNT                (BC),
        .GAP_HALF_PERIODS           (GHP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .tick      (tick),
`ifdef BLINKER_BURST_DONE_EN
        .blink     (blink),
        .burst_done(burst_done)
`else
        .blink     (blink)
`endif
    );

    typedef struct {
        int         cyc;
        int         kind;
        logic [1:0] val;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cur   = -1;

    int          t = 0;
    int          n = 0;
    int          bk[CH];
    logic [1:0]  last_blink = 2'b00;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cur, act, req);
        end
    endtask

    // monitor: pops every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            while (q.size() > 0 && q[0].cyc <= cur) begin
                e = q.pop_front();
                if (e.cyc != cur) begin
                    check("stale_entry", 2'b01, 2'b00);
                end else if (e.kind == K_TICK) begin
                    check("tick", {1'b0, tick}, e.val);
                end else if (e.kind == K_BLINK) begin
                    check("blink", blink, e.val);
`ifdef BLINKER_BURST_DONE_EN
                end else begin
                    check("burst_done", burst_done, e.val);
`endif
                end
            end
        end
    end

    function automatic logic burst_level(input int k);
        int j;
        if (k == 0) return 1'b0;
        j = (k - 1) % PER;
        return (j < 2 * BC - 1) && (j % 2 == 0);
    endfunction

    // apply inputs for cycle n, queue tick for n and registered outputs for n+1
    task automatic step(input logic en, input logic [2*CH-1:0] md);
        logic       te;
        logic       ph;
        logic [1:0] bx;
        logic [1:0] dx;
        logic [1:0] m;
        enable = en;
        mode   = md;
        cur    = n;
        te = en && (t % HALFP == HALFP - 1);
        q.push_back('{n, K_TICK, {1'b0, te}});
        if (en) t++;
        ph = ((t / HALFP) % 2) == 1;
        bx = 2'b00;
        dx = 2'b00;
        for (int ch = 0; ch < CH; ch++) begin
            m = md[2*ch +: 2];
            if (m != 2'b11) begin
                bk[ch] = 0;
            end else if (te) begin
                bk[ch]++;
                dx[ch] = ((bk[ch] - 1) % PER) == 2 * BC - 1;
            end
            case (m)
                2'b00:   bx[ch] = 1'b0;
                2'b01:   bx[ch] = 1'b1;
                2'b10:   bx[ch] = ph;
                default: bx[ch] = burst_level(bk[ch]);
            endcase
        end
        q.push_back('{n + 1, K_BLINK, bx});
`ifdef BLINKER_BURST_DONE_EN
        q.push_back('{n + 1, K_DONE, dx});
`endif
        last_blink = bx;
        @(posedge clk);
        #2;
        n++;
    endtask

    initial begin
        bk[0]  = 0;
        bk[1]  = 0;
        rst    = 1'b0;
        enable = 1'b0;
        mode   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_blink", blink, 2'b00);
        check("reset_tick", {1'b0, tick}, 2'b00);
`ifdef BLINKER_BURST_DONE_EN
        check("reset_done", burst_done, 2'b00);
`endif
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        q.push_back('{0, K_BLINK, 2'b00});
`ifdef BLINKER_BURST_DONE_EN
        q.push_back('{0, K_DONE, 2'b00});
`endif

        repeat (25) step(1'b1, 4'b0000);
        repeat (45) step(1'b1, 4'b0110);
        repeat (7)  step(1'b0, 4'b0110);
        repeat (13) step(1'b1, 4'b0110);
        repeat (20) step(1'b1, 4'b0010);

        // enter BURST on ch0 in the same cycle as a tick
        for (int k = 0; k < HALFP && (t % HALFP) != HALFP - 1; k++) step(1'b1, 4'b0010);
        step(1'b1, 4'b1011);
        repeat (129) step(1'b1, 4'b1011);
        repeat (5)   step(1'b0, 4'b1011);
        repeat (20)  step(1'b1, 4'b1011);

        // leave BURST during the second pulse, then re-enter
        for (int k = 0; k < 2 * PER * HALFP && !(bk[0] > 0 && (bk[0] - 1) % PER == 2); k++)
            step(1'b1, 4'b1011);
        repeat (3)  step(1'b1, 4'b1011);
        repeat (2)  step(1'b1, 4'b1010);
        repeat (75) step(1'b1, 4'b1011);

        // stop on the first cycle of a fresh burst high
        for (int k = 0; k < 2 * PER * HALFP && last_blink[0] !== 1'b0; k++) step(1'b1, 4'b1011);
        for (int k = 0; k < 2 * PER * HALFP && last_blink[0] !== 1'b1; k++) step(1'b1, 4'b1011);
        cur = n;
        @(negedge clk);
        #1;
        check("pre_reset_blink0", {1'b0, blink[0]}, 2'b01);
        rst = 1'b0;
        #1;
        check("async_reset_blink", blink, 2'b00);
        check("async_reset_tick", {1'b0, tick}, 2'b00);
`ifdef BLINKER_BURST_DONE_EN
        check("async_reset_done", burst_done, 2'b00);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("held_reset_blink", blink, 2'b00);
        check("queue_drained", {1'b0, q.size() == 0}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blinker_multi.md
Name: blinker_multi

Overview:
- Parametrised successor to the single-output blinker: CHANNELS independent indicator outputs share one clock divider.
- Each channel has its own mode: OFF, ON, BLINK or BURST (N pulses followed by a gap).
- Sits between the stopwatch control logic and board LEDs, e.g. "running" steady, "paused" blink, "lap captured" burst.

Parameters:
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100000000: frequency of clk.
- BLINK_FREQUENCY_IN_HZ, 2: full on/off frequency in BLINK and BURST modes.
- CHANNELS, 4: number of independent outputs, >=1.
- BURST_COUNT, 3: ON pulses per burst, >=1.
- GAP_HALF_PERIODS, 4: off time after the last burst pulse, in half-periods, >=1.

Ports:
- clk  input  1  board clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  high = divider runs; low = timing frozen.
- mode  input  2*CHANNELS  bits [2i+1:2i] select channel i mode: 00 OFF, 01 ON, 10 BLINK, 11 BURST.
- tick  output  1  one-cycle pulse at each half-period boundary.
- blink  output  CHANNELS  registered indicator outputs.
- burst_done  output  CHANNELS  only when BLINKER_BURST_DONE_EN is defined.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is asynchronous and active-low.
  - While rst=0: divider=0, phase=0, tick=0, blink=0, all burst FSMs IDLE, burst_done=0.
- Divider:
  - HALF = BOARD_CLOCK_FREQUENCY_IN_HZ/(2*BLINK_FREQUENCY_IN_HZ), integer division.
  - HALF<1 is an elaboration error.
  - Counter width is clog2(HALF). It counts 0..HALF-1 and wraps.
  - tick=1 for exactly the cycle in which counter==HALF-1 and enable=1.
  - The first tick after reset release with enable=1 occurs in cycle HALF-1, counting from cycle 0.
- enable=0:
  - Counter, phase and all FSMs hold; tick=0.
  - OFF/ON mode changes still take effect.
- phase: toggles on every tick edge.
- All outputs are registered. blink[i] next value is computed from the next-state values:
  - OFF: 0.
  - ON: 1.
  - BLINK: phase_next. blink changes on the same edge as phase.
  - BURST: (burst_state_next==ON).
- Mode changes are seen on the next clk edge (1-cycle latency). No glitch or extra cycle is produced.
- Burst FSM, per channel. States IDLE, ON, OFF, GAP; pulse_cnt width clog2(BURST_COUNT+1); gap_cnt width clog2(GAP_HALF_PERIODS+1).
  - Any mode other than 11: state forced to IDLE, counters cleared.
  - IDLE with mode=11: stays IDLE (blink=0) until the next tick, then goes to ON with pulse_cnt=1.
  - ON at tick: if pulse_cnt==BURST_COUNT, go to GAP with gap_cnt=0; else go to OFF.
  - OFF at tick: go to ON, pulse_cnt++.
  - GAP at tick: if gap_cnt==GAP_HALF_PERIODS-1, go to ON with pulse_cnt=1; else gap_cnt++.
  - Without a tick, state holds.
  - Resulting waveform: BURST_COUNT high half-periods, each separated by one low half-period, then GAP_HALF_PERIODS low half-periods. Repeats.
- Boundary cases:
  - Leaving BURST mid-burst and re-entering restarts from IDLE. Burst state is never resumed.
  - Mode change in the same cycle as a tick: the new mode is evaluated with that tick.
  - Channels are independent. A BLINK channel is always aligned to the shared phase, not to the time it entered BLINK mode.
  - rst assertion mid-burst immediately clears all state.

Optional Feature:
- Macro: BLINKER_BURST_DONE_EN.
- Defined:
  - Adds the burst_done[CHANNELS] output port.
  - burst_done[i] is a registered one-cycle pulse on the edge where channel i moves from ON to GAP.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: BOARD=20, BLINK=1 (HALF=10), CHANNELS=2, rst=0 for 5 cycles. Then rst=1, enable=1, mode=0 -> blink=00 always, tick every 10 cycles.
- BLINK: mode ch0=10 -> blink[0] rises at the first tick edge, then toggles every 10 cycles (period 20). Deassert enable for 7 cycles -> blink[0] and the tick spacing stretch by 7 cycles.
- ON/OFF latency: mode ch1 01->00 at an arbitrary cycle -> blink[1] falls exactly 1 clk later. The blink[0] pattern is unaffected.
- BURST: BURST_COUNT=2, GAP_HALF_PERIODS=3, mode ch0=11 -> low until the first tick. Then high 10, low 10, high 10, low 30, repeating with period 60. With the macro defined, burst_done[0] pulses once per period, at the edge where the second high ends.
- Mid-burst exit: switch ch0 11->10->11 during the second pulse -> burst restarts from IDLE (waits for the next tick, then pulse 1).
- Async reset: rst=0 mid-cycle during a burst high -> blink, tick and burst_done go to 0 immediately, without waiting for a clk edge.
